// File: rtl/mux.sv
// Purpose: 1-bit 2:1 multiplexer, basic building block for the shared data path.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs and select immediately.
//
// Ports:
//   i_a   - input selected when i_sel = 0
//   i_b   - input selected when i_sel = 1
//   i_sel - select
//   o_y   - selected output
module mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_arbiter.sv
// Purpose: two-requester arbiter with bounded hold time driving a shared muxed channel.
// Latency: grant appears one cycle after the request is sampled; data path is combinational.
// Backpressure: a requester keeps the grant while asserting req, but yields after MAX_HOLD
//               cycles if the other side is waiting; a lone requester holds indefinitely.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   req_a / req_b     - channel requests
//   data_a / data_b   - requester payloads (WIDTH bits)
//   gnt_a / gnt_b     - current owner of the channel (one-hot or zero)
//   sel               - registered mux select, 0 = A, 1 = B
//   valid             - data_out carries granted payload
//   data_out          - shared channel, zero when no grant
module mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_A = 2'd1;
    localparam logic [1:0] S_GRANT_B = 2'd2;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic             r_sel;
    logic [3:0]       r_cnt;
    logic             r_last_served;

    logic [1:0]       w_nxt_state;
    logic [WIDTH-1:0] w_mux;

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_a && !req_b)
                    w_nxt_state = S_GRANT_A;
                else if (req_b && !req_a)
                    w_nxt_state = S_GRANT_B;
                else if (req_a && req_b)
                    // Tie goes to whoever was not served most recently
                    w_nxt_state = (r_last_served == SIDE_A) ? S_GRANT_B : S_GRANT_A;
                else
                    w_nxt_state = S_IDLE;
            end
            S_GRANT_A: begin
                if (!req_a)
                    w_nxt_state = req_b ? S_GRANT_B : S_IDLE;
                else if (req_b && (r_cnt == CNT_MAX))
                    w_nxt_state = S_GRANT_B;
            end
            S_GRANT_B: begin
                if (!req_b)
                    w_nxt_state = req_a ? S_GRANT_A : S_IDLE;
                else if (req_a && (r_cnt == CNT_MAX))
                    w_nxt_state = S_GRANT_A;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State, select, hold counter and fairness history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel         <= SIDE_A;
            r_cnt         <= 4'd0;
            r_last_served <= SIDE_B;
        end else begin
            r_state <= w_nxt_state;
            if ((w_nxt_state == S_GRANT_A) && (r_state != S_GRANT_A)) begin
                r_sel         <= SIDE_A;
                r_last_served <= SIDE_A;
                r_cnt         <= 4'd0;
            end else if ((w_nxt_state == S_GRANT_B) && (r_state != S_GRANT_B)) begin
                r_sel         <= SIDE_B;
                r_last_served <= SIDE_B;
                r_cnt         <= 4'd0;
            end else if ((w_nxt_state == r_state) && (r_state != S_IDLE)
                         && (r_cnt != CNT_MAX)) begin
                // Saturating so a lone holder always yields on the next edge once contested
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        gnt_a = (r_state == S_GRANT_A);
        gnt_b = (r_state == S_GRANT_B);
        valid = gnt_a | gnt_b;
    end

    assign sel = r_sel;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            mux u_mux (
                .i_a   (data_a[gi]),
                .i_b   (data_b[gi]),
                .i_sel (r_sel),
                .o_y   (w_mux[gi])
            );
        end
    endgenerate

    assign data_out = w_mux & {WIDTH{valid}};

endmodule

// File: tb/tb_mux_arbiter.sv
// Purpose: directed self-checking bench for mux_arbiter.
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: n/a.
module tb_mux_arbiter;

    logic       clk;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       valid;
    logic [3:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;

    mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for the channel: expected grant decides the payload
    task automatic expect_state(input string tag, input logic ega, input logic egb,
                                input logic esel);
        logic [3:0] exp_dat;
        exp_dat = ega ? data_a : (egb ? data_b : 4'h0);
        check({tag, ".gnt_a"},    32'(gnt_a), 32'(ega));
        check({tag, ".gnt_b"},    32'(gnt_b), 32'(egb));
        check({tag, ".valid"},    32'(valid), 32'(ega | egb));
        check({tag, ".sel"},      32'(sel), 32'(esel));
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dat));
        check({tag, ".mutex"},    32'(gnt_a & gnt_b), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 4'hA;
        data_b = 4'h5;
        @(negedge clk);

        // Reset state
        step();
        expect_state("reset", 1'b0, 1'b0, 1'b0);
        check("reset.cnt",  32'(dut.r_cnt), 32'd0);
        check("reset.last", 32'(dut.r_last_served), 32'd1);

        // Both requesting: alternate 4 cycles each, A first
        reset = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (((i / 4) % 2) == 0)
                expect_state($sformatf("alt%0d", i), 1'b1, 1'b0, 1'b0);
            else
                expect_state($sformatf("alt%0d", i), 1'b0, 1'b1, 1'b1);
            check($sformatf("alt%0d.cnt", i), 32'(dut.r_cnt), 32'(i % 4));
        end

        // Lone B holds, counter saturates at 3
        do_reset();
        req_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_state($sformatf("loneb%0d", i), 1'b0, 1'b1, 1'b1);
            check($sformatf("loneb%0d.cnt", i), 32'(dut.r_cnt), 32'((i < 3) ? i : 3));
        end
        // A arrives: saturated counter forces switch on the next edge
        req_a = 1'b1;
        step();
        expect_state("loneb_yield", 1'b1, 1'b0, 1'b0);

        // A drops at counter 1 while B requests: direct switch, no gap
        do_reset();
        data_a = 4'h3;
        data_b = 4'hC;
        req_a  = 1'b1;
        step();
        expect_state("drop.ga0", 1'b1, 1'b0, 1'b0);
        step();
        check("drop.cnt1", 32'(dut.r_cnt), 32'd1);
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        expect_state("drop.gb", 1'b0, 1'b1, 1'b1);

        // Reset mid-grant drops grant despite requests
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        expect_state("midrst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        expect_state("midrst.tie", 1'b1, 1'b0, 1'b0);

        // Both drop in GRANT_A: IDLE, sel held at 0
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        expect_state("idle", 1'b0, 1'b0, 1'b0);
        check("idle.last", 32'(dut.r_last_served), 32'd0);
        step();
        expect_state("idle2", 1'b0, 1'b0, 1'b0);
        // Tie after A was last served goes to B
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        expect_state("tie_b", 1'b0, 1'b1, 1'b1);

        // Payload change mid-grant propagates combinationally
        data_b = 4'h6;
        #1;
        check("comb.data_out", 32'(data_out), 32'h6);
        data_a = 4'hF;
        #1;
        check("comb.ignore_a", 32'(data_out), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, data width of each requester and of the output.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles while the other side is requesting; legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_a  input  1  requester A wants the shared channel.
REQ-006 req_b  input  1  requester B wants the shared channel.
REQ-007 data_a  input  WIDTH  requester A payload.
REQ-008 data_b  input  WIDTH  requester B payload.
REQ-009 gnt_a  output  1  A owns the channel this cycle.
REQ-010 gnt_b  output  1  B owns the channel this cycle.
REQ-011 sel  output  1  registered multiplexer select; 0 = A, 1 = B.
REQ-012 valid  output  1  data_out carries granted payload.
REQ-013 data_out  output  WIDTH  shared channel output.

Function
REQ-014 States SHALL be IDLE, GRANT_A and GRANT_B; gnt_a = (state==GRANT_A), gnt_b = (state==GRANT_B), valid = gnt_a | gnt_b.
REQ-015 gnt_a and gnt_b SHALL never both be 1.
REQ-016 data_out SHALL equal data_a when valid and sel=0, data_b when valid and sel=1, and all zeros when valid=0 (combinational from inputs and registered sel).
REQ-017 Grant latency: a request sampled at edge k SHALL produce its grant in the cycle after edge k; no combinational path from req_* to gnt_*.
REQ-018 IDLE: only req_a -> GRANT_A; only req_b -> GRANT_B; both -> side opposite to last_served; neither -> stay IDLE.
REQ-019 last_served register SHALL update to the granted side on every entry into GRANT_A or GRANT_B.
REQ-020 sel SHALL update on the same edge as the state: 0 on entry to GRANT_A, 1 on entry to GRANT_B, unchanged in IDLE.
REQ-021 A hold counter (4 bits) SHALL clear to 0 on every grant entry and increment each further cycle in the same grant state, saturating at MAX_HOLD-1.
REQ-022 In GRANT_X: if req_X=0 -> GRANT_other when other requests, else IDLE.
REQ-023 In GRANT_X with req_X=1: if other requests and counter == MAX_HOLD-1 -> GRANT_other; otherwise stay.
REQ-024 A lone requester SHALL keep the grant indefinitely (counter saturated) until the other side requests, then switch on the next edge.
REQ-025 Switch GRANT_A <-> GRANT_B SHALL be direct, with no IDLE bubble.
REQ-026 Requester drop and opposite request arriving on the same edge SHALL switch without an idle cycle (REQ-022).

Reset
REQ-027 With reset=1 at an edge, next cycle: state IDLE, gnt_a=0, gnt_b=0, valid=0, sel=0, data_out=0, counter=0, last_served=B (so A wins the first tie).
REQ-028 Reset asserted mid-grant SHALL drop the grant on that edge regardless of requests; reset has priority over all transitions.

Structure
REQ-029 State encodings and the A/B identifiers SHALL be localparams inside the module; no shared package is needed.
REQ-030 The output path SHALL instantiate the team's existing 1-bit 2:1 multiplexer `mux` WIDTH times (generate loop), driven by sel, followed by AND gating with valid.
REQ-031 Next-state logic SHALL be one combinational block; state, sel, counter and last_served SHALL be registered in one clocked block.

Verification
REQ-032 Reset then req_a=1, req_b=1 from cycle 0, data_a=4'hA, data_b=4'h5 -> GRANT_A for 4 cycles (data_out=A), then GRANT_B for 4 cycles (data_out=5), alternating.
REQ-033 Only req_b=1 for 10 cycles -> gnt_b=1 from the cycle after the first edge, held all 10 cycles, sel=1, counter saturates at 3.
REQ-034 GRANT_A at counter 1, req_a drops while req_b=1 on the same edge -> next cycle gnt_b=1, no valid=0 gap.
REQ-035 GRANT_B active, reset=1 for one edge -> next cycle gnt_b=0, valid=0, data_out=0, sel=0; then both requests -> A granted first.
REQ-036 Both requests deasserted in GRANT_A -> IDLE, valid=0, data_out=0, sel stays 0; a later tie grants B (last_served=A).
REQ-037 All scenarios SHALL check gnt_a & gnt_b == 0 every cycle and data_out against a reference model.
